mac_array_acc: RTL
==================

Name: mac_array_acc

Overview:
Parametrised successor to the lane-parallel MAC array. It has NUM_MAC signed multiply-accumulate lanes that accumulate a programmable-length vector stream under a valid/ready handshake. Each lane has an optional bias preload, saturating arithmetic and sticky overflow flags. A reduction mode sums all lanes into one result. It sits between the operand buffers and the activation/requant stage of the CNN datapath.

Parameters:
NUM_MAC, 4, number of parallel MAC lanes
IN_WIDTH, 8, signed operand width per lane
ACC_WIDTH, 24, signed accumulator/result width per lane
LEN_WIDTH, 10, width of the beat-count configuration
SAT_EN, 1, 1 = saturate accumulators to the signed ACC_WIDTH range; 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; latches cfg_len, cfg_reduce, bias_in; accepted only in IDLE
cfg_len  in  LEN_WIDTH  number of input beats to accumulate
cfg_reduce  in  1  1 = output the sum of all lanes on lane 0
bias_in  in  NUM_MAC*ACC_WIDTH  per-lane initial accumulator value (signed)
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat
a  in  NUM_MAC*IN_WIDTH  lane i operand at [i*IN_WIDTH +: IN_WIDTH], signed
b  in  NUM_MAC*IN_WIDTH  as a
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
acc_out  out  NUM_MAC*ACC_WIDTH  per-lane results, or the reduced result on lane 0
ovf  out  NUM_MAC  sticky per-lane overflow/saturation flags for the current job
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; in_ready = 0, out_valid = 0, busy = 0, acc_out = 0, ovf = 0. Accumulators, pipeline registers and the beat counter clear. Reset mid-job aborts the job with no output.
- States: IDLE, ACCUM, FLUSH, DONE.
- IDLE: start=1 loads the accumulators from bias_in, clears ovf, and latches cfg_len and cfg_reduce.
  - cfg_len != 0: go to ACCUM.
  - cfg_len == 0: go to FLUSH. The result equals the bias (reduced if cfg_reduce=1).
- start outside IDLE is ignored.
- ACCUM: in_ready = 1 while remaining beats > 0. A beat transfers on in_valid && in_ready.
  - Stage 1 registers the per-lane full-precision signed products (2*IN_WIDTH bits).
  - Stage 2 adds the sign-extended product to the accumulator one cycle later.
  - After the cfg_len-th beat transfers, in_ready drops the next cycle and the state moves to FLUSH.
- FLUSH: one cycle; the last product enters the accumulator. The next cycle enters DONE.
  - acc_out is registered on the FLUSH->DONE transition.
  - Latency: last beat accepted in cycle t gives out_valid=1 in cycle t+2.
- Reduction (cfg_reduce=1): lane 0 = saturating/wrapping sum of all lanes, computed at ACC_WIDTH+clog2(NUM_MAC) precision then clamped or wrapped. Other lanes output 0. ovf[0] also sets if the reduction overflows.
- DONE: out_valid = 1 and acc_out stays stable until out_ready. On out_valid && out_ready, go to IDLE; out_valid drops the next cycle. ovf holds until the next start.
- Arithmetic:
  - SAT_EN=1: a result above the signed max clamps to 2^(ACC_WIDTH-1)-1; below the min clamps to -2^(ACC_WIDTH-1). The lane's ovf bit sets.
  - SAT_EN=0: wrap, but still set ovf on signed overflow.
- Input gaps (in_valid=0) stall accumulation without loss. An out_ready held low stalls indefinitely.
- start in the same cycle out_valid/out_ready completes is ignored, because the state is DONE, not IDLE.

Decomposition:
- Shared package mac_pkg holds:
  - state enum (IDLE/ACCUM/FLUSH/DONE)
  - sat_add function (signed add with clamp and overflow flag)
  - ACC_MAX/ACC_MIN constants derived from ACC_WIDTH
- One sub-module, mac_lane: product register, accumulator, saturation, ovf bit. Generated NUM_MAC times.
- The top level holds the FSM, beat counter, reduction tree and output register.

Test Plan:
- Basic: NUM_MAC=4, bias=0, cfg_len=3, a=b={1,2,3,4} per beat -> acc_out={3,12,27,48}, out_valid exactly 2 cycles after the 3rd beat, ovf=0.
- Bias + signed: bias={100,0,0,-5}, cfg_len=2, a={-3,..}, b={4,..} per beat; lane 3 -> acc_out[0]=76, lane 3 = -5 + 2*(-12) = -29.
- Saturation: ACC_WIDTH=16, SAT_EN=1, a=b=127, cfg_len=3 -> lane = 32767, ovf=1. With SAT_EN=0 -> 48387 wraps to -17149, ovf=1.
- Reduce: cfg_reduce=1, cfg_len=1, a={1,2,3,4}, b={1,1,1,1} -> acc_out lane 0 = 10, lanes 1-3 = 0.
- Handshake: random in_valid gaps and out_ready held low 5 cycles -> identical result, acc_out stable while stalled, start during DONE ignored. cfg_len=0 -> result = bias after the FLUSH cycle.
- Async reset asserted mid-ACCUM (after 2 of 5 beats) -> all outputs 0 immediately. A new job afterwards produces a correct result with no residue.

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and helpers for the MAC array: controller state
//                encoding, accumulator range limits and the saturating /
//                wrapping fit function used by both the lanes and the
//                reduction stage.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Working width for all range arithmetic. Wide enough that any
    // accumulator (up to 62 bits) plus a product, or a sum over a few lanes,
    // never overflows before it is fitted back into the accumulator width.
    localparam int SAT_W = 64;

    localparam int ACC_WIDTH_DEF = 24;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    ovf;
    } sat_res_t;

    function automatic logic signed [SAT_W-1:0] acc_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] acc_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    localparam logic signed [SAT_W-1:0] ACC_MAX = acc_max(ACC_WIDTH_DEF);
    localparam logic signed [SAT_W-1:0] ACC_MIN = acc_min(ACC_WIDTH_DEF);

    // Fit an exact value into a signed field of 'width' bits: clamp when
    // sat_en is set, otherwise keep the low bits (two's-complement wrap).
    // The overflow flag is raised in both cases.
    function automatic sat_res_t sat_fit(input logic signed [SAT_W-1:0] sum,
                                         input int                      width,
                                         input bit                      sat_en);
        sat_res_t                r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] wrapped;
        hi      = acc_max(width);
        lo      = acc_min(width);
        wrapped = (sum <<< (SAT_W - width)) >>> (SAT_W - width);
        r.ovf   = (sum > hi) || (sum < lo);
        if (sat_en && (sum > hi))
            r.value = hi;
        else if (sat_en && (sum < lo))
            r.value = lo;
        else
            r.value = wrapped;
        return r;
    endfunction

    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] x,
                                         input logic signed [SAT_W-1:0] y,
                                         input int                      width,
                                         input bit                      sat_en);
        return sat_fit(x + y, width, sat_en);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lane
//  Description : One signed MAC lane. Stage 1 registers the full-precision
//                product, stage 2 adds it into the accumulator with
//                saturation or wrap and a sticky overflow flag.
//  Ports       : load      - preload accumulator with bias, clear ovf
//                beat      - operand beat transfers this cycle
//                bias,a,b  - preload value and signed operands
//                acc       - accumulator register
//                acc_next  - value the accumulator takes at the next edge
//                ovf       - sticky overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module mac_lane
    import mac_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter bit SAT_EN    = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        beat,
    input  logic signed [ACC_WIDTH-1:0] bias,
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    output logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [ACC_WIDTH-1:0] acc_next,
    output logic                        ovf
);

    logic signed [2*IN_WIDTH-1:0] r_prod;
    logic                         r_prod_vld;
    logic signed [2*IN_WIDTH-1:0] w_prod;
    logic signed [SAT_W-1:0]      w_acc_ext;
    logic signed [SAT_W-1:0]      w_prod_ext;
    sat_res_t                     w_sum;
    logic                         w_ovf_set;

    always_comb begin
        w_prod     = $signed({{IN_WIDTH{a[IN_WIDTH-1]}}, a})
                   * $signed({{IN_WIDTH{b[IN_WIDTH-1]}}, b});
        w_acc_ext  = {{(SAT_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
        w_prod_ext = {{(SAT_W-2*IN_WIDTH){r_prod[2*IN_WIDTH-1]}}, r_prod};
        w_sum      = sat_add(w_acc_ext, w_prod_ext, ACC_WIDTH, SAT_EN);
        acc_next   = r_prod_vld ? w_sum.value[ACC_WIDTH-1:0] : acc;
        w_ovf_set  = r_prod_vld & w_sum.ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            acc        <= '0;
            ovf        <= 1'b0;
        end else if (load) begin
            r_prod_vld <= 1'b0;
            acc        <= bias;
            ovf        <= 1'b0;
        end else begin
            r_prod_vld <= beat;
            if (beat)
                r_prod <= w_prod;
            acc <= acc_next;
            ovf <= ovf | w_ovf_set;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_array_acc.sv
`default_nettype none
// ============================================================================
//  Module      : mac_array_acc
//  Description : NUM_MAC-lane signed MAC array accumulating a cfg_len-beat
//                operand stream with optional bias preload, saturation and
//                an optional all-lane reduction onto lane 0.
//  Ports       : start/cfg_len/cfg_reduce/bias_in - job setup (IDLE only)
//                in_valid/in_ready/a/b            - operand stream
//                out_valid/out_ready/acc_out      - result handshake
//                ovf  - sticky per-lane overflow, busy - not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module mac_array_acc
    import mac_pkg::*;
#(
    parameter int NUM_MAC   = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 10,
    parameter bit SAT_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_WIDTH-1:0]          cfg_len,
    input  logic                          cfg_reduce,
    input  logic [NUM_MAC*ACC_WIDTH-1:0]  bias_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_MAC*IN_WIDTH-1:0]   a,
    input  logic [NUM_MAC*IN_WIDTH-1:0]   b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_MAC*ACC_WIDTH-1:0]  acc_out,
    output logic [NUM_MAC-1:0]            ovf,
    output logic                          busy
);

    state_t                         r_state;
    logic [LEN_WIDTH-1:0]           r_rem;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic                           r_busy;
    logic                           r_reduce;
    logic                           r_red_ovf;
    logic [NUM_MAC*ACC_WIDTH-1:0]   r_acc_out;

    logic                           w_load;
    logic                           w_beat;
    logic signed [ACC_WIDTH-1:0]    w_acc      [NUM_MAC];
    logic signed [ACC_WIDTH-1:0]    w_acc_next [NUM_MAC];
    logic [NUM_MAC-1:0]             w_lane_ovf;
    logic signed [SAT_W-1:0]        w_red_sum;
    sat_res_t                       w_red;

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_beat = in_valid && r_in_ready;

    generate
        for (genvar i = 0; i < NUM_MAC; i++) begin : g_lane
            mac_lane #(
                .IN_WIDTH  (IN_WIDTH),
                .ACC_WIDTH (ACC_WIDTH),
                .SAT_EN    (SAT_EN)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .load     (w_load),
                .beat     (w_beat),
                .bias     (bias_in[i*ACC_WIDTH +: ACC_WIDTH]),
                .a        (a[i*IN_WIDTH +: IN_WIDTH]),
                .b        (b[i*IN_WIDTH +: IN_WIDTH]),
                .acc      (w_acc[i]),
                .acc_next (w_acc_next[i]),
                .ovf      (w_lane_ovf[i])
            );
        end
    endgenerate

    // Reduction over the accumulators' next values so that the product
    // retired during FLUSH is included. The SAT_W working width exceeds
    // ACC_WIDTH+clog2(NUM_MAC), so the sum is exact before fitting.
    always_comb begin
        w_red_sum = '0;
        for (int i = 0; i < NUM_MAC; i++)
            w_red_sum = w_red_sum
                      + {{(SAT_W-ACC_WIDTH){w_acc_next[i][ACC_WIDTH-1]}}, w_acc_next[i]};
        w_red = sat_fit(w_red_sum, ACC_WIDTH, SAT_EN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_reduce    <= 1'b0;
            r_red_ovf   <= 1'b0;
            r_acc_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_reduce  <= cfg_reduce;
                        r_red_ovf <= 1'b0;
                        r_rem     <= cfg_len;
                        r_busy    <= 1'b1;
                        if (cfg_len != '0) begin
                            r_state    <= ST_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_beat) begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == LEN_WIDTH'(1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state     <= ST_DONE;
                    r_out_valid <= 1'b1;
                    if (r_reduce)
                        r_red_ovf <= w_red.ovf;
                    for (int i = 0; i < NUM_MAC; i++) begin
                        if (!r_reduce)
                            r_acc_out[i*ACC_WIDTH +: ACC_WIDTH] <= w_acc_next[i];
                        else if (i == 0)
                            r_acc_out[i*ACC_WIDTH +: ACC_WIDTH] <= w_red.value[ACC_WIDTH-1:0];
                        else
                            r_acc_out[i*ACC_WIDTH +: ACC_WIDTH] <= '0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ovf    = w_lane_ovf;
        ovf[0] = w_lane_ovf[0] | r_red_ovf;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign acc_out   = r_acc_out;

endmodule
`default_nettype wire
